// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
// One request is outstanding at a time; the response is a single-cycle pulse.
interface pc_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Instruction memory side
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the rv32i core.
// Fetches one instruction at pc, presents it to decode and holds it until the
// core retires it, then advances pc to the sequential, branch/JAL or JALR target.
// Targets that are not word aligned redirect to TRAP_VEC with a one-cycle flag.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_unit_if.master  imem,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      pc_plus4,
  input  logic             pc_update,
  input  logic             rel_jump,
  input  logic [31:0]      rel_offset,
  input  logic             jalr_en,
  input  logic [31:0]      jalr_base,
  input  logic [31:0]      jalr_imm,
  output logic             misaligned_trap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        trap_q, trap_d;

  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        target_misaligned;

  // Select the retire target; JALR wins over a relative jump, all adds wrap.
  always_comb begin
    jalr_sum = jalr_base + jalr_imm;
    if (jalr_en) begin
      target = jalr_sum & ~32'h0000_0001;
    end else if (rel_jump) begin
      target = pc_q + rel_offset;
    end else begin
      target = pc_q + 32'd4;
    end
    target_misaligned = (target[1:0] != 2'b00);
  end

  // State register and datapath flops with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end

  // Next-state and next-datapath logic for the fetch sequencer.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    trap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_d = S_HOLD;
          instr_d = imem.imem_rsp_data;
        end
      end
      S_HOLD: begin
        if (pc_update) begin
          state_d = S_REQ;
          if (target_misaligned) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end else begin
            pc_d   = target;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and registered datapath.
  always_comb begin
    imem.imem_req_valid = (state_q == S_REQ);
    imem.imem_req_addr  = pc_q;
    instr_valid         = (state_q == S_HOLD);
    instr               = instr_q;
    instr_pc            = pc_q;
    pc_plus4            = pc_q + 32'd4;
    misaligned_trap     = trap_q;
  end

endmodule
